// File: rtl/sq_multi_if.sv
// D-cache store request channel of the multi-lane store queue.
// The queue drives the request; the cache answers with accept.
interface sq_multi_if;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic [1:0]  dc_req_size;
  logic [31:0] dc_req_data;
  logic        dc_req_accept;

  modport master (
    output dc_req_valid,
    output dc_req_addr,
    output dc_req_size,
    output dc_req_data,
    input  dc_req_accept
  );

  modport slave (
    input  dc_req_valid,
    input  dc_req_addr,
    input  dc_req_size,
    input  dc_req_data,
    output dc_req_accept
  );
endinterface

// File: rtl/sq_multi.sv
// Multi-lane store queue: wide enqueue/commit, indexed writeback,
// age-ordered store-to-load forwarding, tail-restore squash.
module sq_multi #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int SQ_SIZE        = 16,
  parameter int ROB_IDX        = 6,
  parameter int IDX_WIDTH      = $clog2(SQ_SIZE),
  parameter int PW             = IDX_WIDTH + 1,
  parameter int FW             = $clog2(SQ_SIZE + 1),
  parameter int CW             = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic [DISPATCH_WIDTH-1:0] enq_valid,
  input  logic [DISPATCH_WIDTH-1:0][1:0] enq_size,
  input  logic [DISPATCH_WIDTH-1:0][ROB_IDX-1:0] enq_rob_idx,
  output logic enq_ready,
  output logic [DISPATCH_WIDTH-1:0][PW-1:0] enq_sq_ptr,
  output logic [FW-1:0] free_num_slot,
  input  logic exe_valid,
  input  logic [PW-1:0] exe_sq_ptr,
  input  logic [31:0] exe_addr,
  input  logic [31:0] exe_data,
  input  logic [CW-1:0] commit_num,
  input  logic ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [1:0] ld_size,
  input  logic [PW-1:0] ld_age_ptr,
  output logic fwd_hit,
  output logic [31:0] fwd_data,
  output logic fwd_stall,
  sq_multi_if.master dc,
  input  logic squash_valid,
  input  logic [PW-1:0] squash_tail
);

  typedef logic [IDX_WIDTH-1:0] idx_t;
  typedef logic [PW-1:0] ptr_t;

  logic              e_valid      [SQ_SIZE];
  logic [1:0]        e_size       [SQ_SIZE];
  logic [ROB_IDX-1:0] e_rob_idx   [SQ_SIZE];
  logic              e_addr_valid [SQ_SIZE];
  logic [31:0]       e_addr       [SQ_SIZE];
  logic [31:0]       e_data       [SQ_SIZE];
  logic              e_committed  [SQ_SIZE];

  ptr_t head, cmt, tail;
  ptr_t occ, span;
  logic [FW-1:0] cnt;
  logic do_enq, exe_ok, retire;
  idx_t head_idx, exe_idx;
  idx_t enq_idx [DISPATCH_WIDTH];
  idx_t cmt_idx [COMMIT_WIDTH];
  logic kill [SQ_SIZE];
  logic ovl  [SQ_SIZE];
  logic cov  [SQ_SIZE];

  function automatic logic [32:0] nbytes(input logic [1:0] sz);
    unique case (sz)
      2'd0:    nbytes = 33'd1;
      2'd1:    nbytes = 33'd2;
      default: nbytes = 33'd4;
    endcase
  endfunction

  assign occ           = tail - head;
  assign free_num_slot = FW'(SQ_SIZE) - FW'(occ);
  assign head_idx      = head[IDX_WIDTH-1:0];
  assign exe_idx       = exe_sq_ptr[IDX_WIDTH-1:0];
  assign span          = tail - squash_tail;

  always_comb begin
    cnt = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      cnt           = cnt + FW'(enq_valid[l]);
      enq_sq_ptr[l] = tail + PW'(l);
      enq_idx[l]    = tail[IDX_WIDTH-1:0] + IDX_WIDTH'(l);
    end
    for (int k = 0; k < COMMIT_WIDTH; k++)
      cmt_idx[k] = cmt[IDX_WIDTH-1:0] + IDX_WIDTH'(k);
  end

  assign enq_ready = free_num_slot >= cnt;
  assign do_enq    = enq_ready && !squash_valid && (cnt != '0);

  // Squash range is [squash_tail, tail), measured as a wrap-safe offset.
  always_comb begin
    for (int i = 0; i < SQ_SIZE; i++) begin
      kill[i] = squash_valid &&
                ({1'b0, idx_t'(IDX_WIDTH'(i) - squash_tail[IDX_WIDTH-1:0])} < span);
    end
  end

  assign exe_ok = exe_valid && e_valid[exe_idx] && !kill[exe_idx];

  assign dc.dc_req_valid = e_valid[head_idx] && e_committed[head_idx] &&
                           e_addr_valid[head_idx];
  assign dc.dc_req_addr  = dc.dc_req_valid ? e_addr[head_idx] : '0;
  assign dc.dc_req_size  = dc.dc_req_valid ? e_size[head_idx] : '0;
  assign dc.dc_req_data  = dc.dc_req_valid ? e_data[head_idx] : '0;
  assign retire          = dc.dc_req_valid && dc.dc_req_accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
      for (int i = 0; i < SQ_SIZE; i++) begin
        e_valid[i]      <= 1'b0;
        e_addr_valid[i] <= 1'b0;
        e_committed[i]  <= 1'b0;
      end
    end else begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (do_enq && enq_valid[l]) begin
          e_valid[enq_idx[l]]      <= 1'b1;
          e_size[enq_idx[l]]       <= enq_size[l];
          e_rob_idx[enq_idx[l]]    <= enq_rob_idx[l];
          e_addr_valid[enq_idx[l]] <= 1'b0;
          e_committed[enq_idx[l]]  <= 1'b0;
        end
      end
      if (exe_ok) begin
        e_addr[exe_idx]       <= exe_addr;
        e_data[exe_idx]       <= exe_data;
        e_addr_valid[exe_idx] <= 1'b1;
      end
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (CW'(k) < commit_num) e_committed[cmt_idx[k]] <= 1'b1;
      cmt <= cmt + PW'(commit_num);
      if (retire) begin
        e_valid[head_idx] <= 1'b0;
        head              <= head + 1'b1;
      end
      for (int i = 0; i < SQ_SIZE; i++)
        if (kill[i]) e_valid[i] <= 1'b0;
      if (squash_valid)
        tail <= squash_tail;
      else if (do_enq)
        tail <= tail + PW'(cnt);
    end
  end

  logic [32:0] ld_lo, ld_hi;
  assign ld_lo = {1'b0, ld_addr};
  assign ld_hi = ld_lo + nbytes(ld_size);

  always_comb begin
    for (int i = 0; i < SQ_SIZE; i++) begin
      ovl[i] = ({1'b0, e_addr[i]} < ld_hi) &&
               (ld_lo < {1'b0, e_addr[i]} + nbytes(e_size[i]));
      cov[i] = ({1'b0, e_addr[i]} <= ld_lo) &&
               ({1'b0, e_addr[i]} + nbytes(e_size[i]) >= ld_hi);
    end
  end

  ptr_t older, p;
  idx_t sel, pi;
  logic found;
  logic [1:0] off;
  logic [31:0] shifted, mask;

  // Walk from the youngest older store toward head; first relevant wins.
  always_comb begin
    older = ld_age_ptr - head;
    found = 1'b0;
    sel   = '0;
    p     = '0;
    pi    = '0;
    for (int j = 0; j < SQ_SIZE; j++) begin
      p  = ld_age_ptr - PW'(j + 1);
      pi = p[IDX_WIDTH-1:0];
      if (!found && (PW'(j) < older) && e_valid[pi] &&
          (!e_addr_valid[pi] || ovl[pi])) begin
        found = 1'b1;
        sel   = pi;
      end
    end
  end

  always_comb begin
    off     = ld_addr[1:0] - e_addr[sel][1:0];
    shifted = e_data[sel] >> {off, 3'b000};
    unique case (ld_size)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    if (ld_valid && found) begin
      if (!e_addr_valid[sel] || !cov[sel]) begin
        fwd_stall = 1'b1;
      end else begin
        fwd_hit  = 1'b1;
        fwd_data = shifted & mask;
      end
    end
  end

endmodule

// File: tb/tb_sq_multi.sv
// Directed bench for sq_multi: enqueue, retire, forwarding,
// squash and pointer wrap, checked with immediate assertions.
module tb_sq_multi;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] enq_valid;
  logic [1:0][1:0] enq_size;
  logic [1:0][5:0] enq_rob_idx;
  logic enq_ready;
  logic [1:0][4:0] enq_sq_ptr;
  logic [4:0] free_num_slot;
  logic exe_valid;
  logic [4:0] exe_sq_ptr;
  logic [31:0] exe_addr, exe_data;
  logic [1:0] commit_num;
  logic ld_valid;
  logic [31:0] ld_addr;
  logic [1:0] ld_size;
  logic [4:0] ld_age_ptr;
  logic fwd_hit, fwd_stall;
  logic [31:0] fwd_data;
  logic squash_valid;
  logic [4:0] squash_tail;
  int checks = 0;
  int failures = 0;

  sq_multi_if dc();

  sq_multi dut (
    .clock(clk), .reset(rst),
    .enq_valid(enq_valid), .enq_size(enq_size),
    .enq_rob_idx(enq_rob_idx), .enq_ready(enq_ready),
    .enq_sq_ptr(enq_sq_ptr), .free_num_slot(free_num_slot),
    .exe_valid(exe_valid), .exe_sq_ptr(exe_sq_ptr),
    .exe_addr(exe_addr), .exe_data(exe_data),
    .commit_num(commit_num),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_age_ptr(ld_age_ptr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .dc(dc.master),
    .squash_valid(squash_valid), .squash_tail(squash_tail)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    assert (enq_valid !== 2'b10) else $error("illegal non-packed enq_valid");

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = '0;
    enq_size = '{2'd2, 2'd2};
    enq_rob_idx = '0;
    exe_valid = 0; exe_sq_ptr = '0; exe_addr = '0; exe_data = '0;
    commit_num = '0;
    ld_valid = 0; ld_addr = '0; ld_size = '0; ld_age_ptr = '0;
    squash_valid = 0; squash_tail = '0;
    dc.dc_req_accept = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic exe(input logic [4:0] ptr, input logic [31:0] a,
                     input logic [31:0] d);
    exe_valid = 1; exe_sq_ptr = ptr; exe_addr = a; exe_data = d;
    tick();
    exe_valid = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz,
                      input logic [4:0] age);
    ld_valid = 1; ld_addr = a; ld_size = sz; ld_age_ptr = age;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and fill to exhaustion
    do_reset();
    #1;
    chk("rst_free", 32'(free_num_slot), 32'd16);
    chk("rst_ready", 32'(enq_ready), 32'd1);
    chk("rst_dcv", 32'(dc.dc_req_valid), 32'd0);
    chk("rst_hit", 32'(fwd_hit), 32'd0);
    chk("rst_stall", 32'(fwd_stall), 32'd0);
    chk("rst_ptr0", 32'(enq_sq_ptr[0]), 32'd0);
    chk("rst_ptr1", 32'(enq_sq_ptr[1]), 32'd1);
    for (int k = 0; k < 7; k++) begin
      enq_valid = 2'b11;
      #1;
      chk("fill_free", 32'(free_num_slot), 32'(16 - 2 * k));
      chk("fill_ready", 32'(enq_ready), 32'd1);
      tick();
    end
    enq_valid = 2'b01;
    #1;
    chk("fill_free2", 32'(free_num_slot), 32'd2);
    tick();
    enq_valid = 2'b11;
    #1;
    chk("full_free1", 32'(free_num_slot), 32'd1);
    chk("full_ready0", 32'(enq_ready), 32'd0);
    tick();
    enq_valid = 2'b00;
    #1;
    chk("full_noalloc_free", 32'(free_num_slot), 32'd1);
    chk("full_noalloc_tail", 32'(enq_sq_ptr[0]), 32'd15);
    enq_valid = 2'b01;
    tick();
    enq_valid = 2'b00;
    #1;
    chk("full_free0", 32'(free_num_slot), 32'd0);

    // Retire hold under back-pressure
    do_reset();
    enq_valid = 2'b01;
    tick();
    enq_valid = 2'b00;
    exe(5'd0, 32'h100, 32'hAABBCCDD);
    commit_num = 2'd1;
    #1;
    chk("ret_pre_commit", 32'(dc.dc_req_valid), 32'd0);
    tick();
    commit_num = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ret_hold_v", 32'(dc.dc_req_valid), 32'd1);
      chk("ret_hold_a", dc.dc_req_addr, 32'h100);
      chk("ret_hold_d", dc.dc_req_data, 32'hAABBCCDD);
      chk("ret_hold_free", 32'(free_num_slot), 32'd15);
      tick();
    end
    dc.dc_req_accept = 1;
    #1;
    chk("ret_acc_v", 32'(dc.dc_req_valid), 32'd1);
    tick();
    dc.dc_req_accept = 0;
    #1;
    chk("ret_done_v", 32'(dc.dc_req_valid), 32'd0);
    chk("ret_done_free", 32'(free_num_slot), 32'd16);

    // Forwarding: youngest-first, coverage, byte extraction
    do_reset();
    enq_valid = 2'b11;
    enq_size = '{2'd0, 2'd2};
    tick();
    idle();
    exe(5'd0, 32'h100, 32'h11223344);
    exe(5'd1, 32'h101, 32'h00000055);
    load(32'h101, 2'd0, 5'd2);
    chk("fw_byte_hit", 32'(fwd_hit), 32'd1);
    chk("fw_byte_data", fwd_data, 32'h55);
    load(32'h100, 2'd1, 5'd2);
    chk("fw_part_stall", 32'(fwd_stall), 32'd1);
    chk("fw_part_hit", 32'(fwd_hit), 32'd0);
    load(32'h101, 2'd0, 5'd1);
    chk("fw_old_hit", 32'(fwd_hit), 32'd1);
    chk("fw_old_data", fwd_data, 32'h33);
    load(32'h104, 2'd2, 5'd2);
    chk("fw_miss_hit", 32'(fwd_hit), 32'd0);
    chk("fw_miss_stall", 32'(fwd_stall), 32'd0);
    load(32'h101, 2'd0, 5'd2);
    ld_valid = 0;
    #1;
    chk("fw_off_hit", 32'(fwd_hit), 32'd0);
    chk("fw_off_stall", 32'(fwd_stall), 32'd0);

    // Unknown older address stalls; resolved non-overlap clears
    do_reset();
    enq_valid = 2'b11;
    tick();
    enq_valid = 2'b00;
    exe(5'd1, 32'h300, 32'h33333333);
    load(32'h100, 2'd2, 5'd2);
    chk("av_stall", 32'(fwd_stall), 32'd1);
    chk("av_hit", 32'(fwd_hit), 32'd0);
    exe(5'd0, 32'h200, 32'h22222222);
    #1;
    chk("av_clear_hit", 32'(fwd_hit), 32'd0);
    chk("av_clear_stall", 32'(fwd_stall), 32'd0);
    load(32'h300, 2'd2, 5'd2);
    chk("av_word_hit", 32'(fwd_hit), 32'd1);
    chk("av_word_data", fwd_data, 32'h33333333);

    // Squash beats same-cycle enqueue and drops exe to killed entry
    do_reset();
    enq_valid = 2'b11;
    repeat (3) tick();
    enq_valid = 2'b00;
    commit_num = 2'd2;
    exe(5'd0, 32'h000, 32'h0);
    commit_num = 2'd0;
    exe(5'd1, 32'h040, 32'h1);
    exe(5'd2, 32'h080, 32'h2);
    exe(5'd3, 32'h0C0, 32'h3);
    squash_valid = 1; squash_tail = 5'd4;
    enq_valid = 2'b11;
    exe_valid = 1; exe_sq_ptr = 5'd5;
    exe_addr = 32'h500; exe_data = 32'h55555555;
    #1;
    chk("sq_ready", 32'(enq_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("sq_tail", 32'(enq_sq_ptr[0]), 32'd4);
    chk("sq_free", 32'(free_num_slot), 32'd12);
    load(32'h500, 2'd2, 5'd6);
    chk("sq_gone_hit", 32'(fwd_hit), 32'd0);
    chk("sq_gone_stall", 32'(fwd_stall), 32'd0);
    ld_valid = 0;
    enq_valid = 2'b11;
    tick();
    enq_valid = 2'b00;
    load(32'h500, 2'd2, 5'd6);
    chk("sq_realloc_stall", 32'(fwd_stall), 32'd1);
    chk("sq_realloc_free", 32'(free_num_slot), 32'd10);
    exe(5'd5, 32'h500, 32'hCAFEF00D);
    #1;
    chk("sq_new_hit", 32'(fwd_hit), 32'd1);
    chk("sq_new_data", fwd_data, 32'hCAFEF00D);

    // Pointer wrap through steady enqueue/commit/retire
    do_reset();
    for (int i = 0; i < 47; i++) begin
      enq_valid = 2'b01;
      #1;
      chk("wrap_ptr", 32'(enq_sq_ptr[0]), 32'(i % 32));
      tick();
      enq_valid = 2'b00;
      commit_num = 2'd1;
      exe(5'(i % 32), 32'h1000 + 32'(4 * i), 32'(i));
      commit_num = 2'd0;
      dc.dc_req_accept = 1;
      #1;
      chk("wrap_dcv", 32'(dc.dc_req_valid), 32'd1);
      chk("wrap_dca", dc.dc_req_addr, 32'h1000 + 32'(4 * i));
      tick();
      dc.dc_req_accept = 0;
    end
    enq_valid = 2'b11;
    #1;
    chk("wrap_lane0", 32'(enq_sq_ptr[0]), 32'd15);
    chk("wrap_lane1", 32'(enq_sq_ptr[1]), 32'd16);
    tick();
    enq_valid = 2'b00;
    exe(5'd15, 32'h700, 32'hDEADBEEF);
    exe(5'd16, 32'h704, 32'h12345678);
    load(32'h702, 2'd1, 5'd17);
    chk("wrap_fw_hit", 32'(fwd_hit), 32'd1);
    chk("wrap_fw_half", fwd_data, 32'hDEAD);
    load(32'h704, 2'd2, 5'd17);
    chk("wrap_fw_word", fwd_data, 32'h12345678);
    load(32'h704, 2'd2, 5'd16);
    chk("wrap_fw_young_hit", 32'(fwd_hit), 32'd0);
    chk("wrap_fw_young_stall", 32'(fwd_stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
